// File: rtl/fetch_decode_queue.sv
// ---------------------------------------------------------------------------
// fetch_decode_queue
//
// Elastic IF/ID boundary: a DEPTH-entry show-ahead FIFO between the fetch
// stage and the decode stage. Fetch pushes {instr, pc, pcplus4} with a
// valid/ready handshake. Decode sees the oldest entry combinationally on
// d_* and pops it with its own valid/ready handshake. A decode stall only
// back-pressures fetch once every entry is occupied.
//
// flush (branch mispredict / jump) empties the queue in one cycle and also
// discards any push or pop offered in the same cycle. While the queue is
// empty, d_* present a NOP bubble (NOP_INSTR, pc 0, pcplus4 0).
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   flush      in   discard all entries and any same-cycle push/pop
//   f_valid    in   fetch presents an entry
//   f_ready    out  queue has a free slot (depends on state only)
//   f_instr    in   fetched instruction
//   f_pc       in   PC of the fetched instruction
//   f_pcplus4  in   PC+4 of the fetched instruction
//   d_valid    out  head entry is valid
//   d_ready    in   decode consumes the head entry this cycle
//   d_instr    out  head instruction, NOP_INSTR when empty
//   d_pc       out  head PC, 0 when empty
//   d_pcplus4  out  head PC+4, 0 when empty
//   count      out  number of occupied entries (registered)
// ---------------------------------------------------------------------------
module fetch_decode_queue #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 2,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h00000013
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,

    input  logic                          f_valid,
    output logic                          f_ready,
    input  logic [DATA_WIDTH-1:0]         f_instr,
    input  logic [DATA_WIDTH-1:0]         f_pc,
    input  logic [DATA_WIDTH-1:0]         f_pcplus4,

    output logic                          d_valid,
    input  logic                          d_ready,
    output logic [DATA_WIDTH-1:0]         d_instr,
    output logic [DATA_WIDTH-1:0]         d_pc,
    output logic [DATA_WIDTH-1:0]         d_pcplus4,

    output logic [$clog2(DEPTH+1)-1:0]    count
);

    // Counter must hold 0..DEPTH; pointers 0..DEPTH-1 (at least one bit so
    // the DEPTH=1 case still has a legal vector).
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] instr;
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] pcplus4;
    } entry_t;

    entry_t          storage [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   cnt;

    logic            push;
    logic            pop;
    logic [PW-1:0]   rd_ptr_nxt;
    logic [PW-1:0]   wr_ptr_nxt;

    // -----------------------------------------------------------------------
    // Handshake. f_ready looks only at cnt, so there is no combinational path
    // from d_ready to f_ready; a pop while full opens a slot one cycle later.
    // -----------------------------------------------------------------------
    assign f_ready = (cnt != CNT_FULL);
    assign d_valid = (cnt != '0);
    assign push    = f_valid && f_ready && !flush;
    assign pop     = d_valid && d_ready && !flush;
    assign count   = cnt;

    // Wrap by explicit compare: DEPTH need not be a power of two, so letting
    // the pointer overflow its bit width would skip or revisit slots.
    assign rd_ptr_nxt = (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
    assign wr_ptr_nxt = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);

    // -----------------------------------------------------------------------
    // Storage write.
    // NOTE: the entry array has no reset; cnt alone decides what is valid, and
    // leaving the data unreset keeps it a plain register file/RAM.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            storage[wr_ptr] <= '{instr: f_instr, pc: f_pc, pcplus4: f_pcplus4};
        end
    end

    // -----------------------------------------------------------------------
    // Pointer and occupancy update. Priority: rst > flush > push/pop.
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr_nxt;
            end
            if (pop) begin
                rd_ptr <= rd_ptr_nxt;
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            if (push && !pop) begin
                cnt <= cnt + CW'(1);
            end else if (pop && !push) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Show-ahead output: head entry when occupied, NOP bubble when empty.
    // NOTE: every output gets a default before the conditional so no path
    // leaves it unassigned and no latch is inferred.
    // -----------------------------------------------------------------------
    always_comb begin
        d_instr   = NOP_INSTR;
        d_pc      = '0;
        d_pcplus4 = '0;
        if (d_valid) begin
            d_instr   = storage[rd_ptr].instr;
            d_pc      = storage[rd_ptr].pc;
            d_pcplus4 = storage[rd_ptr].pcplus4;
        end
    end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_decode_queue
//
// Two instances (DEPTH=2 and DEPTH=3) driven in lockstep with the same
// fetch/decode stimulus. Each has its own scoreboard queue: an entry is
// pushed when the bench's model says the DUT accepts it, and the head of the
// queue is compared against d_* every cycle and popped when decode consumes.
// ---------------------------------------------------------------------------
module tb_fetch_decode_queue;

    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcplus4;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        f_valid;
    logic [31:0] f_instr;
    logic [31:0] f_pc;
    logic [31:0] f_pcplus4;
    logic        d_ready;

    logic        f_ready_o   [2];
    logic        d_valid_o   [2];
    logic [31:0] d_instr_o   [2];
    logic [31:0] d_pc_o      [2];
    logic [31:0] d_pcplus4_o [2];
    logic [1:0]  count_o     [2];

    int n_checks = 0;
    int n_errors = 0;

    ent_t        q2[$];
    ent_t        q3[$];
    logic [31:0] popped2[$];
    logic [31:0] popped3[$];
    bit          last_push3;
    int          max_cnt2;
    bit          seen_300;

    always #5 clk = ~clk;

    fetch_decode_queue #(.DATA_WIDTH(32), .DEPTH(2), .NOP_INSTR(NOP)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .f_valid   (f_valid),
        .f_ready   (f_ready_o[0]),
        .f_instr   (f_instr),
        .f_pc      (f_pc),
        .f_pcplus4 (f_pcplus4),
        .d_valid   (d_valid_o[0]),
        .d_ready   (d_ready),
        .d_instr   (d_instr_o[0]),
        .d_pc      (d_pc_o[0]),
        .d_pcplus4 (d_pcplus4_o[0]),
        .count     (count_o[0])
    );

    fetch_decode_queue #(.DATA_WIDTH(32), .DEPTH(3), .NOP_INSTR(NOP)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .f_valid   (f_valid),
        .f_ready   (f_ready_o[1]),
        .f_instr   (f_instr),
        .f_pc      (f_pc),
        .f_pcplus4 (f_pcplus4),
        .d_valid   (d_valid_o[1]),
        .d_ready   (d_ready),
        .d_instr   (d_instr_o[1]),
        .d_pc      (d_pc_o[1]),
        .d_pcplus4 (d_pcplus4_o[1]),
        .count     (count_o[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Fetch entry derived from the PC so instr/pcplus4 mix-ups are visible.
    task automatic drive(input logic [31:0] pc);
        f_pc      = pc;
        f_instr   = 32'hA5000000 ^ (pc << 4) ^ 32'h33;
        f_pcplus4 = pc + 32'd4;
    endtask

    // Compare one DUT against its model state and decide the model's move.
    task automatic eval_dut(input int id, input int depth, input int n, input ent_t head,
                            output bit do_push, output bit do_pop);
        string p;
        p = (id == 0) ? "d2" : "d3";
        check({p, ".count"},   32'(count_o[id]), 32'(n));
        check({p, ".f_ready"}, 32'(f_ready_o[id]), 32'(n != depth));
        check({p, ".d_valid"}, 32'(d_valid_o[id]), 32'(n != 0));
        check({p, ".d_instr"},   d_instr_o[id],   (n != 0) ? head.instr   : NOP);
        check({p, ".d_pc"},      d_pc_o[id],      (n != 0) ? head.pc      : 32'h0);
        check({p, ".d_pcplus4"}, d_pcplus4_o[id], (n != 0) ? head.pcplus4 : 32'h0);
        if (d_valid_o[id] === 1'b1 && d_pc_o[id] === 32'h300) seen_300 = 1'b1;
        do_push = !rst && !flush && f_valid && (n < depth);
        do_pop  = !rst && !flush && d_ready && (n > 0);
    endtask

    // One clock cycle: check at the falling edge, advance models after the
    // rising edge. Inputs are changed by the caller after this returns.
    task automatic step();
        ent_t h2, h3, cur;
        bit   p2, o2, p3, o3, clr;
        @(negedge clk);
        h2 = '0;
        h3 = '0;
        if (q2.size() > 0) h2 = q2[0];
        if (q3.size() > 0) h3 = q3[0];
        cur = '{instr: f_instr, pc: f_pc, pcplus4: f_pcplus4};
        clr = rst || flush;
        eval_dut(0, 2, q2.size(), h2, p2, o2);
        eval_dut(1, 3, q3.size(), h3, p3, o3);
        if (int'(count_o[0]) > max_cnt2) max_cnt2 = int'(count_o[0]);
        if (o2) popped2.push_back(d_pc_o[0]);
        if (o3) popped3.push_back(d_pc_o[1]);
        @(posedge clk);
        #1;
        if (clr) begin
            q2.delete();
            q3.delete();
        end else begin
            if (o2) void'(q2.pop_front());
            if (p2) q2.push_back(cur);
            if (o3) void'(q3.pop_front());
            if (p3) q3.push_back(cur);
        end
        last_push3 = p3;
    endtask

    task automatic drain();
        f_valid = 1'b0;
        d_ready = 1'b1;
        for (int c = 0; c < 8 && (q2.size() > 0 || q3.size() > 0); c++) step();
        check("drain.empty", 32'(q2.size() + q3.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst      = 1'b1;
        flush    = 1'b0;
        f_valid  = 1'b1;
        d_ready  = 1'b0;
        max_cnt2 = 0;
        seen_300 = 1'b0;
        drive(32'h50);

        // Reset held two cycles with f_valid high: nothing captured.
        @(posedge clk);
        #1;
        step();
        step();
        rst     = 1'b0;
        f_valid = 1'b0;
        step();
        check("reset.d_instr", d_instr_o[0], NOP);

        // Latency and order with decode always ready.
        d_ready  = 1'b1;
        max_cnt2 = 0;
        popped2.delete();
        foreach (popped2[i]) popped2.delete(i);
        for (int i = 0; i < 3; i++) begin
            f_valid = 1'b1;
            drive(32'h100 + 32'(4 * i));
            step();
        end
        f_valid = 1'b0;
        step();
        step();
        check("lat.max_count", 32'(max_cnt2), 32'd1);
        check("lat.n_popped", 32'(popped2.size()), 32'd3);
        for (int i = 0; i < 3 && i < popped2.size(); i++)
            check("lat.order", popped2[i], 32'h100 + 32'(4 * i));
        drain();

        // Full / backpressure.
        popped2.delete();
        d_ready = 1'b0;
        f_valid = 1'b1;
        drive(32'h200);
        step();
        drive(32'h204);
        step();
        drive(32'h208);
        step();
        check("full.d2_f_ready", 32'(f_ready_o[0]), 32'd0);
        d_ready = 1'b1;
        step();
        d_ready = 1'b0;
        step();
        f_valid = 1'b0;
        drain();
        check("full.n_popped", 32'(popped2.size()), 32'd3);
        for (int i = 0; i < 3 && i < popped2.size(); i++)
            check("full.order", popped2[i], 32'h200 + 32'(4 * i));

        // Flush with simultaneous push and pop.
        seen_300 = 1'b0;
        d_ready  = 1'b0;
        f_valid  = 1'b1;
        drive(32'h2a0);
        step();
        drive(32'h2a4);
        step();
        flush   = 1'b1;
        d_ready = 1'b1;
        drive(32'h300);
        step();
        flush   = 1'b0;
        f_valid = 1'b0;
        step();
        check("flush.d_instr", d_instr_o[0], NOP);
        step();
        step();
        check("flush.no_0x300", 32'(seen_300), 32'd0);

        // Wrap-around stream of 10 entries, decode ready toggling.
        popped3.delete();
        k = 0;
        for (int c = 0; c < 80 && (k < 10 || q3.size() > 0); c++) begin
            d_ready = (c % 2 == 0);
            f_valid = (k < 10);
            if (k < 10) drive(32'(4 * k));
            step();
            if (last_push3) k++;
        end
        check("wrap.accepted", 32'(k), 32'd10);
        check("wrap.n_popped", 32'(popped3.size()), 32'd10);
        for (int i = 0; i < 10 && i < popped3.size(); i++)
            check("wrap.order", popped3[i], 32'(4 * i));
        drain();

        // Reset mid-operation with push and pop offered.
        d_ready = 1'b0;
        f_valid = 1'b1;
        drive(32'h4a0);
        step();
        drive(32'h4a4);
        step();
        check("rstmid.count_before", 32'(count_o[0]), 32'd2);
        rst     = 1'b1;
        d_ready = 1'b1;
        drive(32'h4a8);
        step();
        rst     = 1'b0;
        f_valid = 1'b0;
        d_ready = 1'b0;
        step();
        popped2.delete();
        f_valid = 1'b1;
        drive(32'h400);
        step();
        f_valid = 1'b0;
        step();
        check("rstmid.head", d_pc_o[0], 32'h400);
        check("rstmid.count", 32'(count_o[0]), 32'd1);
        drain();
        check("rstmid.n_popped", 32'(popped2.size()), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_decode_queue.md
Name: fetch_decode_queue

Overview:
Elastic IF/ID boundary replacing the fixed single-entry fetch/decode register with a parametrised DEPTH-entry show-ahead queue.
- Fetch pushes {instr, pc, pcplus4} under a valid/ready handshake; decode pops under its own valid/ready handshake.
- Decode stalls no longer freeze fetch until the queue fills.
- flush (branch mispredict / jump) empties the queue in one cycle; an empty queue presents a NOP bubble.

Parameters:
DATA_WIDTH, 32, width of instr, pc and pcplus4 fields
DEPTH, 2, number of queue entries; legal range 1..16, power of two not required
NOP_INSTR, 32'h00000013, instruction word driven on d_instr while the queue is empty (addi x0,x0,0)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset: synchronous, active-high
flush  input  1  discard all entries and any same-cycle push
f_valid  input  1  fetch presents a valid entry
f_ready  output  1  queue can accept an entry this cycle
f_instr  input  DATA_WIDTH  fetched instruction
f_pc  input  DATA_WIDTH  PC of the fetched instruction
f_pcplus4  input  DATA_WIDTH  PC+4 of the fetched instruction
d_valid  output  1  head entry is valid
d_ready  input  1  decode consumes the head entry this cycle
d_instr  output  DATA_WIDTH  head instruction, or NOP_INSTR when empty
d_pc  output  DATA_WIDTH  head PC, or 0 when empty
d_pcplus4  output  DATA_WIDTH  head PC+4, or 0 when empty
count  output  $clog2(DEPTH+1)  number of occupied entries

Behaviour:
- State:
  - circular storage of DEPTH entries;
  - rd_ptr and wr_ptr, each 0..DEPTH-1, wrapping DEPTH-1 -> 0 (explicit compare, not bit truncation);
  - occupancy counter cnt, 0..DEPTH.
- Handshake signals:
  - f_ready = (cnt != DEPTH). Purely a function of state; no combinational path from d_ready.
  - d_valid = (cnt != 0).
  - push = f_valid && f_ready && !flush.
  - pop = d_valid && d_ready && !flush.
- Show-ahead output: d_instr, d_pc and d_pcplus4 are driven combinationally from storage[rd_ptr] when cnt != 0. When cnt == 0 they are NOP_INSTR, 0 and 0.
- Update priority per edge: rst > flush > push/pop.
  - rst: rd_ptr = wr_ptr = cnt = 0. After reset: f_ready=1, d_valid=0, d_instr=NOP_INSTR, d_pc=0, d_pcplus4=0, count=0. Storage contents need not be cleared. Reset asserted mid-stream discards everything in flight.
  - flush (rst low): rd_ptr = wr_ptr = cnt = 0 next cycle. Any same-cycle f_valid/d_ready is ignored: no entry written, no entry consumed. The cycle after a flush shows d_valid=0 and f_ready=1.
  - push only: write storage[wr_ptr], advance wr_ptr, cnt+1.
  - pop only: advance rd_ptr, cnt-1.
  - push and pop together (requires 0 < cnt < DEPTH): write and advance both pointers; cnt unchanged.
- Latency: one cycle. An entry pushed at edge N is visible at d_* after edge N. There is no fall-through while empty.
- Full (cnt==DEPTH): f_ready=0, so fetch must hold its f_* inputs. A pop while full frees a slot; f_ready rises the following cycle.
- Empty (cnt==0): d_ready is ignored and count does not underflow.
- Ordering: strict FIFO. Entries leave in push order and no entry is duplicated or dropped, except by flush or rst.
- DEPTH=1 degenerates to a single register with valid bit. It cannot push and pop in the same cycle (f_ready=0 while occupied).
- count = cnt, registered.

Test Plan:
- Reset: hold rst 2 cycles with f_valid=1 -> f_ready=1, d_valid=0, d_instr=32'h00000013, d_pc=0, count=0; no entry is captured.
- Latency and order: push pc=0x100,0x104,0x108 on consecutive cycles with d_ready=1 -> d_pc shows 0x100 one cycle after the first push, then 0x104, 0x108; count never exceeds 1.
- Full / backpressure, DEPTH=2: d_ready=0, push 0x200,0x204 -> count=2, f_ready=0; a third f_valid (0x208) is not taken. Raise d_ready for 1 cycle -> 0x200 popped; f_ready=1 next cycle; 0x208 then accepted; order 0x204, 0x208.
- Flush with simultaneous push/pop: count=2, assert flush with f_valid=1 (pc=0x300) and d_ready=1 -> next cycle count=0, d_valid=0, d_instr=NOP_INSTR; 0x300 never appears at d_pc.
- Wrap-around, DEPTH=3: stream 10 entries pc=0x0..0x24 step 4 with d_ready toggling 1,0,1,0 -> all 10 entries emerge in order with no loss or duplication; count stays within 0..3.
- Reset mid-operation: count=2, assert rst with f_valid=1 and d_ready=1 -> next cycle count=0, d_valid=0; subsequent push 0x400 appears alone at d_pc.
